// File: rtl/bus_mem_model.sv
// bus_mem_model: word memory on the CPU data bus with wait states, byte-lane
// writes, a Ready/Err handshake and an address window.
// Optional feature: define MEM_PROTECT_EN to reject writes below PROT_LIMIT.

module bus_mem_model #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_LOG2  = 10,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PROT_LIMIT  = 32'h0000_0100
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                CS,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [DATA_W-1:0]   Data_BUS_WRITE,
    output logic [DATA_W-1:0]   Data_BUS_READ,
    output logic                Ready,
    output logic                Err
);

    localparam int unsigned NUM_LANES  = DATA_W / 8;
    localparam int unsigned LANE_SHIFT = $clog2(NUM_LANES);
    localparam int unsigned WORDS      = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef MEM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                 state_q;
    logic [3:0]             wait_cnt_q;
    logic                   req_we_q;
    logic [DEPTH_LOG2-1:0]  req_idx_q;
    logic [NUM_LANES-1:0]   req_be_q;
    logic [DATA_W-1:0]      req_wdata_q;
    logic                   req_in_range_q;
    logic                   req_prot_q;

    logic [DATA_W-1:0]      mem [WORDS];

    logic [ADDR_W-1:0]      off;
    logic [ADDR_W-1:0]      idx_full;
    logic                   in_range;
    logic                   below_limit;
    logic                   prot_hit;

    logic                   cur_we;
    logic [DEPTH_LOG2-1:0]  cur_idx;
    logic                   cur_in_range;
    logic                   cur_prot;
    logic                   go_resp;
    logic                   resp_err;
    logic [DATA_W-1:0]      resp_rdata;
    logic                   do_write;

    // Decode the live bus address into word index, window hit and protection hit
    always_comb begin
        off         = ADDR - BASE_ADDR;
        idx_full    = off >> LANE_SHIFT;
        in_range    = ((idx_full >> DEPTH_LOG2) == '0) && (ADDR >= BASE_ADDR);
        below_limit = off < PROT_LIMIT;
        prot_hit    = PROT_EN && below_limit;
    end

    // Select the request that the response is built from; with zero wait states the
    // response is entered straight from IDLE, before the request registers are loaded
    always_comb begin
        if (state_q == StIdle) begin
            cur_we       = WE;
            cur_idx      = idx_full[DEPTH_LOG2-1:0];
            cur_in_range = in_range;
            cur_prot     = prot_hit;
        end else begin
            cur_we       = req_we_q;
            cur_idx      = req_idx_q;
            cur_in_range = req_in_range_q;
            cur_prot     = req_prot_q;
        end
        go_resp    = ((state_q == StIdle) && CS && (WAIT_STATES == 0)) ||
                     ((state_q == StWait) && (wait_cnt_q == '0));
        resp_err   = !cur_in_range || (cur_we && cur_prot);
        resp_rdata = cur_in_range ? mem[cur_idx] : '0;
        do_write   = (state_q == StResp) && req_we_q && req_in_range_q && !req_prot_q;
    end

    // Request FSM with registered Ready/Err/read-data outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            req_we_q       <= 1'b0;
            req_idx_q      <= '0;
            req_be_q       <= '0;
            req_wdata_q    <= '0;
            req_in_range_q <= 1'b0;
            req_prot_q     <= 1'b0;
            Ready          <= 1'b0;
            Err            <= 1'b0;
            Data_BUS_READ  <= '0;
        end else begin
            Ready <= 1'b0;
            Err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (CS) begin
                        req_we_q       <= WE;
                        req_idx_q      <= idx_full[DEPTH_LOG2-1:0];
                        req_be_q       <= BE;
                        req_wdata_q    <= Data_BUS_WRITE;
                        req_in_range_q <= in_range;
                        req_prot_q     <= prot_hit;
                        wait_cnt_q     <= WAIT_LOAD;
                        state_q        <= (WAIT_STATES > 0) ? StWait : StResp;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // CS is deliberately not sampled here; a held CS is taken next cycle
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (go_resp) begin
                Ready <= 1'b1;
                Err   <= resp_err;
                if (!cur_we) begin
                    Data_BUS_READ <= resp_rdata;
                end
            end
        end
    end

    // Byte-lane write on the edge that leaves RESP; the array is never reset
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (req_be_q[i]) begin
                    mem[req_idx_q][i*8 +: 8] <= req_wdata_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_model.sv
// Scoreboard bench for bus_mem_model: four instances covering wait-state
// variants, a small window for range checks and the MEM_PROTECT_EN feature.

module tb_bus_mem_model;

`ifdef MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] data;
        bit          chk;
        bit          err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cs;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata [4];
    logic [3:0]  ready;
    logic [3:0]  err;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          ready_cnt [4];
    logic [31:0] last_rdata;
    exp_t        sb [$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // inst0: WAIT=1, 16 words; inst1: WAIT=0; inst2: WAIT=3; inst3: WAIT=1, protected
    bus_mem_model #(.DEPTH_LOG2(4), .WAIT_STATES(1), .PROT_LIMIT(32'h0)) u_dut0 (
        .CLK(clk), .Reset(rst_n), .CS(cs[0]), .WE(we), .ADDR(addr), .BE(be),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(rdata[0]), .Ready(ready[0]), .Err(err[0])
    );
    bus_mem_model #(.DEPTH_LOG2(4), .WAIT_STATES(0), .PROT_LIMIT(32'h0)) u_dut1 (
        .CLK(clk), .Reset(rst_n), .CS(cs[1]), .WE(we), .ADDR(addr), .BE(be),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(rdata[1]), .Ready(ready[1]), .Err(err[1])
    );
    bus_mem_model #(.DEPTH_LOG2(4), .WAIT_STATES(3), .PROT_LIMIT(32'h0)) u_dut2 (
        .CLK(clk), .Reset(rst_n), .CS(cs[2]), .WE(we), .ADDR(addr), .BE(be),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(rdata[2]), .Ready(ready[2]), .Err(err[2])
    );
    bus_mem_model #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut3 (
        .CLK(clk), .Reset(rst_n), .CS(cs[3]), .WE(we), .ADDR(addr), .BE(be),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(rdata[3]), .Ready(ready[3]), .Err(err[3])
    );

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pop and compare one scoreboard entry per Ready pulse
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (err[i] && !ready[i]) check_eq($sformatf("err_without_ready%0d", i), 1, 0);
            if (ready[i]) begin
                ready_cnt[i]++;
                if (sb.size() == 0) begin
                    check_eq($sformatf("unexpected_ready%0d", i), 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq({mon_e.tag, "_inst"}, i, mon_e.inst);
                    check_eq({mon_e.tag, "_latency"}, cyc, mon_e.cyc);
                    check_eq({mon_e.tag, "_err"}, {31'b0, err[i]}, {31'b0, mon_e.err});
                    if (mon_e.chk) check_eq({mon_e.tag, "_rdata"}, rdata[i], mon_e.data);
                end
                last_rdata = rdata[i];
                done_cnt++;
            end
        end
    end

    // Wait (bounded) for the next Ready seen by the monitor; call at posedge+2
    task automatic wait_done(input string tag, input int start);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk);
            #2;
            if (done_cnt != start) ok = 1'b1;
        end
        if (!ok) begin
            check_eq({tag, "_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    task automatic txn(input string tag, input int inst, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_d,
                       input bit chk, input bit exp_err);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.data = exp_d;
        e.chk  = chk;
        e.err  = exp_err;
        e.cyc  = cyc + 1 + ws_of(inst);
        sb.push_back(e);
        we       = w;
        addr     = a;
        be       = b;
        wdata    = d;
        cs[inst] = 1'b1;
        wait_done(tag, done_cnt);
        cs[inst] = 1'b0;
    endtask

    task automatic wr(input string tag, input int inst, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input bit exp_err);
        txn(tag, inst, 1'b1, a, b, d, '0, 1'b0, exp_err);
    endtask

    task automatic rd(input string tag, input int inst, input logic [31:0] a,
                      input logic [31:0] exp_d, input bit chk, input bit exp_err);
        txn(tag, inst, 1'b0, a, 4'h0, 32'h0, exp_d, chk, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          rc;
        int          base;
        logic [31:0] v;
        exp_t        e;

        for (int i = 0; i < 4; i++) ready_cnt[i] = 0;
        rst_n = 1'b0;
        cs    = '0;
        we    = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("reset_ready%0d", i), {31'b0, ready[i]}, 0);
            check_eq($sformatf("reset_err%0d", i), {31'b0, err[i]}, 0);
            check_eq($sformatf("reset_rdata%0d", i), rdata[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Basic write/read and byte lanes
        wr("wr_deadbeef", 0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
        rd("rd_deadbeef", 0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wr("wr_lanes", 0, 32'h10, 4'b0101, 32'h1122_3344, 1'b0);
        rd("rd_lanes", 0, 32'h10, 32'hDE22_BE44, 1'b1, 1'b0);
        wr("wr_be0", 0, 32'h10, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        rd("rd_be0", 0, 32'h12, 32'hDE22_BE44, 1'b1, 1'b0);

        // Fill the 16-word window, then hit just past its end
        for (int i = 0; i < 16; i++) begin
            v = 32'h1000_0000 + i * 32'h0101;
            wr($sformatf("fill%0d", i), 0, i * 4, 4'hF, v, 1'b0);
        end
        rd("rd_oor", 0, 32'h40, 32'h0, 1'b1, 1'b1);
        wr("wr_oor", 0, 32'h40, 4'hF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = 32'h1000_0000 + i * 32'h0101;
            rd($sformatf("rd_after_oor%0d", i), 0, i * 4, v, 1'b1, 1'b0);
        end

        // Zero wait states, CS held across three reads
        wr("pre0", 1, 32'h0, 4'hF, 32'hA000_0000, 1'b0);
        wr("pre4", 1, 32'h4, 4'hF, 32'hB111_1111, 1'b0);
        wr("pre8", 1, 32'h8, 4'hF, 32'hC222_2222, 1'b0);
        rc   = ready_cnt[1];
        base = cyc;
        for (int j = 0; j < 3; j++) begin
            e.tag  = $sformatf("b2b%0d", j);
            e.inst = 1;
            e.data = (j == 0) ? 32'hA000_0000 : (j == 1) ? 32'hB111_1111 : 32'hC222_2222;
            e.chk  = 1'b1;
            e.err  = 1'b0;
            e.cyc  = base + 1 + 2 * j;
            sb.push_back(e);
        end
        we    = 1'b0;
        addr  = 32'h0;
        cs[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_done($sformatf("b2b%0d", j), done_cnt);
            addr = (j + 1) * 4;
        end
        cs[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("b2b_ready_count", ready_cnt[1] - rc, 3);

        // Reset during WAIT aborts the write
        wr("pre20", 2, 32'h20, 4'hF, 32'h0BAD_F00D, 1'b0);
        rd("rd_pre20", 2, 32'h20, 32'h0BAD_F00D, 1'b1, 1'b0);
        rc    = ready_cnt[2];
        we    = 1'b1;
        addr  = 32'h20;
        be    = 4'hF;
        wdata = 32'h1234_5678;
        cs[2] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        cs[2] = 1'b0;
        #1;
        check_eq("abort_rdata_cleared", rdata[2], 0);
        check_eq("abort_ready_low", {31'b0, ready[2]}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check_eq("abort_no_ready", ready_cnt[2] - rc, 0);
        rd("rd_after_abort", 2, 32'h20, 32'h0BAD_F00D, 1'b1, 1'b0);
        rd("rd_mem_kept", 0, 32'h14, 32'h1000_0505, 1'b1, 1'b0);

        // Write protection below PROT_LIMIT
        wr("wr_prot80", 3, 32'h80, 4'hF, 32'h5A5A_0080, PROT);
        rd("rd_prot80", 3, 32'h80, 32'h5A5A_0080, !PROT, 1'b0);
        if (PROT) check_eq("prot80_unchanged", {31'b0, last_rdata == 32'h5A5A_0080}, 0);
        wr("wr_protfc", 3, 32'hFC, 4'hF, 32'h0000_00FC, PROT);
        rd("rd_protfc", 3, 32'hFC, 32'h0000_00FC, !PROT, 1'b0);
        wr("wr_100", 3, 32'h100, 4'hF, 32'hCAFE_F00D, 1'b0);
        rd("rd_100", 3, 32'h100, 32'hCAFE_F00D, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #2;
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
